// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch sequencer: owns fetch PC, one outstanding req/ack transfer, redirect draining
// Optional ack watchdog with ERR state enabled by `define FETCH_TIMEOUT_EN.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC       = 32'h0000_3000,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pipe_stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        i_inst_req,
   output logic [31:0] i_inst_addr,
   input  logic        i_inst_ack,
   input  logic [31:0] i_inst_rdata,
   output logic        instr_valid,
   output logic [31:0] Instr,
   output logic [31:0] PC,
   output logic        fetch_busy,
   output logic        bus_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_DRAIN,
      S_VALID
`ifdef FETCH_TIMEOUT_EN
      , S_ERR
`endif
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_fetch_pc;
   logic [31:0] r_pending_pc;
   logic [31:0] r_instr;
   logic [31:0] r_pc;
   logic        w_timeout;
   logic        w_waiting;

   // A wait cycle is any bus cycle of the outstanding request without ack.
   assign w_waiting = ((r_state == S_REQ) || (r_state == S_DRAIN)) && !i_inst_ack;

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_bus_err;

   assign w_timeout = w_waiting && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt     <= '0;
         r_bus_err <= 1'b0;
      end else begin
         r_cnt <= (w_waiting && !w_timeout) ? r_cnt + 1'b1 : '0;
         if (w_timeout)
            r_bus_err <= 1'b1;
         else if ((r_state == S_ERR) && redirect)
            r_bus_err <= 1'b0;
      end
   end

   assign bus_err = r_bus_err;
`else
   assign w_timeout = 1'b0;
   assign bus_err   = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  w_state_nxt = S_REQ;
         S_REQ: begin
`ifdef FETCH_TIMEOUT_EN
            if (w_timeout)
               w_state_nxt = S_ERR;
            else
`endif
            if (i_inst_ack && !redirect)
               w_state_nxt = S_VALID;
            else if (!i_inst_ack && redirect)
               w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
`ifdef FETCH_TIMEOUT_EN
            if (w_timeout)
               w_state_nxt = S_ERR;
            else
`endif
            if (i_inst_ack)
               w_state_nxt = S_REQ;
         end
         S_VALID: begin
            if (redirect || !pipe_stall)
               w_state_nxt = S_REQ;
         end
`ifdef FETCH_TIMEOUT_EN
         S_ERR: begin
            if (redirect)
               w_state_nxt = S_REQ;
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_pc   <= RESET_PC;
         r_pending_pc <= '0;
         r_instr      <= '0;
         r_pc         <= RESET_PC;
      end else begin
         case (r_state)
            S_REQ: begin
               if (i_inst_ack) begin
                  if (redirect) begin
                     r_fetch_pc <= redirect_pc;
                  end else begin
                     r_instr    <= i_inst_rdata;
                     r_pc       <= r_fetch_pc;
                     r_fetch_pc <= r_fetch_pc + 32'd4;
                  end
               end else if (redirect && !w_timeout) begin
                  r_pending_pc <= redirect_pc;
               end
            end
            // Data acked in DRAIN belongs to the abandoned path and is dropped.
            S_DRAIN: begin
               if (i_inst_ack)
                  r_fetch_pc <= redirect ? redirect_pc : r_pending_pc;
               else if (redirect && !w_timeout)
                  r_pending_pc <= redirect_pc;
            end
            default: begin
               if (redirect)
                  r_fetch_pc <= redirect_pc;
            end
         endcase
      end
   end

   assign i_inst_req  = (r_state == S_REQ) || (r_state == S_DRAIN);
   assign fetch_busy  = i_inst_req;
   assign i_inst_addr = r_fetch_pc;
   assign instr_valid = (r_state == S_VALID);
   assign Instr       = r_instr;
   assign PC          = r_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl (default build)
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        pipe_stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        i_inst_req;
   logic [31:0] i_inst_addr;
   logic        i_inst_ack;
   logic [31:0] i_inst_rdata;
   logic        instr_valid;
   logic [31:0] Instr;
   logic [31:0] PC;
   logic        fetch_busy;
   logic        bus_err;

   int n_vec = 0;
   int n_err = 0;

   fetch_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .pipe_stall   (pipe_stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .i_inst_req   (i_inst_req),
      .i_inst_addr  (i_inst_addr),
      .i_inst_ack   (i_inst_ack),
      .i_inst_rdata (i_inst_rdata),
      .instr_valid  (instr_valid),
      .Instr        (Instr),
      .PC           (PC),
      .fetch_busy   (fetch_busy),
      .bus_err      (bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic expect_req(input string tag, input logic [31:0] addr);
      chk({tag, "_req"}, 32'(i_inst_req), 32'd1);
      chk({tag, "_addr"}, i_inst_addr, addr);
      chk({tag, "_vld"}, 32'(instr_valid), 32'd0);
   endtask

   task automatic expect_valid(input string tag, input logic [31:0] ins, input logic [31:0] pc_v);
      chk({tag, "_vld"}, 32'(instr_valid), 32'd1);
      chk({tag, "_req"}, 32'(i_inst_req), 32'd0);
      chk({tag, "_instr"}, Instr, ins);
      chk({tag, "_pc"}, PC, pc_v);
   endtask

   initial begin
      reset        = 1'b0;
      pipe_stall   = 1'b0;
      redirect     = 1'b0;
      redirect_pc  = '0;
      i_inst_ack   = 1'b0;
      i_inst_rdata = '0;
      step();
      chk("rst_req",   32'(i_inst_req),  32'd0);
      chk("rst_vld",   32'(instr_valid), 32'd0);
      chk("rst_busy",  32'(fetch_busy),  32'd0);
      chk("rst_err",   32'(bus_err),     32'd0);
      chk("rst_pc",    PC,               32'h0000_3000);
      chk("rst_instr", Instr,            32'h0);
      step();
      reset = 1'b1;
      chk("idle_req", 32'(i_inst_req), 32'd0);

      // ack tied high: REQ/VALID alternate
      i_inst_ack = 1'b1;
      step();
      expect_req("t1a", 32'h0000_3000);
      chk("t1a_busy", 32'(fetch_busy), 32'd1);
      i_inst_rdata = 32'h1111_0000;
      step();
      expect_valid("t1b", 32'h1111_0000, 32'h0000_3000);
      step();
      expect_req("t1c", 32'h0000_3004);
      i_inst_rdata = 32'h2222_0004;
      step();
      expect_valid("t1d", 32'h2222_0004, 32'h0000_3004);
      step();
      expect_req("t1e", 32'h0000_3008);
      i_inst_rdata = 32'h3333_0008;
      step();
      expect_valid("t1f", 32'h3333_0008, 32'h0000_3008);
      i_inst_ack = 1'b0;
      step();
      expect_req("t1g", 32'h0000_300C);

      // asynchronous reset mid-request; ack during and right after reset ignored
      #2;
      reset      = 1'b0;
      i_inst_ack = 1'b1;
      #1;
      chk("arst_req",  32'(i_inst_req), 32'd0);
      chk("arst_busy", 32'(fetch_busy), 32'd0);
      step();
      step();
      reset = 1'b1;
      step();
      i_inst_ack = 1'b0;
      expect_req("t2a", 32'h0000_3000);

      // ack delayed three cycles
      step();
      expect_req("t2b", 32'h0000_3000);
      step();
      expect_req("t2c", 32'h0000_3000);
      step();
      expect_req("t2d", 32'h0000_3000);
      i_inst_ack   = 1'b1;
      i_inst_rdata = 32'hAAAA_3000;
      step();
      expect_valid("t2e", 32'hAAAA_3000, 32'h0000_3000);
      i_inst_ack = 1'b0;
      pipe_stall = 1'b1;

      // stall holds the delivered instruction
      for (int i = 0; i < 4; i++) begin
         step();
         expect_valid("t3s", 32'hAAAA_3000, 32'h0000_3000);
      end
      pipe_stall = 1'b0;
      step();
      expect_req("t3a", 32'h0000_3004);

      // redirect in second wait cycle -> DRAIN, late data dropped
      step();
      expect_req("t4a", 32'h0000_3004);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_4000;
      step();
      redirect = 1'b0;
      expect_req("t4b", 32'h0000_3004);
      i_inst_ack   = 1'b1;
      i_inst_rdata = 32'hDEAD_BEEF;
      step();
      expect_req("t4c", 32'h0000_4000);
      i_inst_rdata = 32'h4444_4000;
      step();
      expect_valid("t4d", 32'h4444_4000, 32'h0000_4000);
      i_inst_ack = 1'b0;

      // two redirects in DRAIN: last one wins
      step();
      expect_req("t5a", 32'h0000_4004);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_4000;
      step();
      expect_req("t5b", 32'h0000_4004);
      redirect_pc = 32'h0000_5000;
      step();
      expect_req("t5c", 32'h0000_4004);
      redirect     = 1'b0;
      i_inst_ack   = 1'b1;
      i_inst_rdata = 32'hBAD0_0001;
      step();
      expect_req("t5d", 32'h0000_5000);
      i_inst_rdata = 32'h5555_5000;
      step();
      expect_valid("t5e", 32'h5555_5000, 32'h0000_5000);

      // redirect from VALID, then ack+redirect together in REQ
      i_inst_ack  = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_6000;
      pipe_stall  = 1'b1;
      step();
      expect_req("t6a", 32'h0000_6000);
      pipe_stall   = 1'b0;
      i_inst_ack   = 1'b1;
      i_inst_rdata = 32'hBAD0_0002;
      redirect_pc  = 32'h0000_7000;
      step();
      expect_req("t6b", 32'h0000_7000);
      redirect     = 1'b0;
      i_inst_rdata = 32'h7777_7000;
      step();
      expect_valid("t6c", 32'h7777_7000, 32'h0000_7000);

      // PC wrap, then ack+redirect together in DRAIN
      redirect     = 1'b1;
      redirect_pc  = 32'hFFFF_FFFC;
      i_inst_ack   = 1'b0;
      step();
      expect_req("t7a", 32'hFFFF_FFFC);
      redirect     = 1'b0;
      i_inst_ack   = 1'b1;
      i_inst_rdata = 32'h0000_00FC;
      step();
      expect_valid("t7b", 32'h0000_00FC, 32'hFFFF_FFFC);
      i_inst_ack = 1'b0;
      step();
      expect_req("t7c", 32'h0000_0000);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_8000;
      step();
      expect_req("t7d", 32'h0000_0000);
      i_inst_ack  = 1'b1;
      redirect_pc = 32'h0000_9000;
      step();
      redirect   = 1'b0;
      i_inst_ack = 1'b0;
      expect_req("t7e", 32'h0000_9000);
      chk("t7_err", 32'(bus_err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
